// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry adder is reused over N cycles
// to form (a + b + cin) mod 2^WIDTH, with carry-out and signed overflow.

module ripple_carry_adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid is held with stable payload until that edge.

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [KW+1:0] nib_lsb;
  logic [3:0]    add_s;
  logic          add_c;

  assign nib_lsb = {k_q, 2'b00};

  ripple_carry_adder_4 u_rca (
    .a_i (a_q[nib_lsb +: 4]),
    .b_i (b_q[nib_lsb +: 4]),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[nib_lsb +: 4] = add_s;
        carry_d             = add_c;
        if (k_q == LAST_K) begin
          // Last nibble: final carry and overflow come straight off the adder.
          state_d = DONE;
          cout_d  = add_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;
endmodule
